// File: rtl/int_fu_pkg.sv
// int_fu_pkg -- shared types for the integer functional-unit controller.
//   fu_op_e    : issue op-code (00 ADD, 01 SUB, 10 XOR, 11 AND)
//   fu_state_e : controller FSM states
//   DATA_W_DEF : default operand/result width
//   CNT_W      : execute down-counter width (covers EXEC_CYCLES up to 15)
package int_fu_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W      = 4;

   typedef enum logic [1:0] {
      OpAdd = 2'b00,
      OpSub = 2'b01,
      OpXor = 2'b10,
      OpAnd = 2'b11
   } fu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRead = 2'b01,
      StExec = 2'b10,
      StWb   = 2'b11
   } fu_state_e;

endpackage

// File: rtl/int_fu_ctrl_if.sv
// int_fu_ctrl_if -- bundle of the issue, operand-read and write-back signals
// between the scoreboard/register-file side (master) and the functional unit
// (slave).
//   issue_*     : instruction issue handshake and fields (Fi, Fj, Fk, op)
//   src_ready   : per-register "no pending writer" bitmap
//   rf_rd_*     : register-file read strobe, addresses and same-cycle data
//   wb_*        : result write-back handshake, destination and data
//   busy        : functional-unit Busy flag
interface int_fu_ctrl_if #(
   parameter int unsigned DATA_W = int_fu_pkg::DATA_W_DEF
);

   logic              issue_valid;
   logic              issue_ready;
   logic [1:0]        issue_op;
   logic [2:0]        issue_dst;
   logic [2:0]        issue_src1;
   logic [2:0]        issue_src2;
   logic [7:0]        src_ready;

   logic              rf_rd_en;
   logic [2:0]        rf_rd_addr1;
   logic [2:0]        rf_rd_addr2;
   logic [DATA_W-1:0] rf_rd_data1;
   logic [DATA_W-1:0] rf_rd_data2;

   logic              wb_valid;
   logic              wb_ready;
   logic [2:0]        wb_dst;
   logic [DATA_W-1:0] wb_data;

   logic              busy;

   modport master (
      output issue_valid, issue_op, issue_dst, issue_src1, issue_src2, src_ready,
      output rf_rd_data1, rf_rd_data2, wb_ready,
      input  issue_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2,
      input  wb_valid, wb_dst, wb_data, busy
   );

   modport slave (
      input  issue_valid, issue_op, issue_dst, issue_src1, issue_src2, src_ready,
      input  rf_rd_data1, rf_rd_data2, wb_ready,
      output issue_ready, rf_rd_en, rf_rd_addr1, rf_rd_addr2,
      output wb_valid, wb_dst, wb_data, busy
   );

endinterface

// File: rtl/int_alu16.sv
// int_alu16 -- combinational integer ALU.
//   a, b   : operands
//   op     : ADD / SUB (modulo 2^DATA_W, carry/borrow dropped), XOR, AND
//   result : operation result
module int_alu16
   import int_fu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  fu_op_e            op,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OpAdd:   result = a + b;
         OpSub:   result = a - b;
         OpXor:   result = a ^ b;
         OpAnd:   result = a & b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/int_fu_ctrl.sv
// int_fu_ctrl -- scoreboard-style integer functional-unit controller.
// Accepts one instruction in IDLE, waits in READ until both source registers
// have no pending writer, reads them, runs the ALU over EXEC_CYCLES cycles and
// holds the result in WB until the scoreboard grants write-back.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards any in-flight instruction)
//   bus   : int_fu_ctrl_if slave port (issue, operand read, write-back, busy)
// Build option: define INT_FU_B2B_EN to let WB accept the next instruction in
// the cycle its result is taken (WB -> READ, no IDLE bubble).
module int_fu_ctrl
   import int_fu_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned EXEC_CYCLES = 2
) (
   input logic          clk,
   input logic          rst_n,
   int_fu_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(EXEC_CYCLES - 1);

   fu_state_e         state_q, state_d;
   fu_op_e            op_q;
   logic [2:0]        dst_q, src1_q, src2_q;
   logic [DATA_W-1:0] opa_q, opb_q, result_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] alu_result;

   logic              operands_ok, accept, exec_done;
   logic              issue_rdy, rd_en, wb_vld, busy_c;
   logic [2:0]        rd_addr1, rd_addr2, wb_dst_c;
   logic [DATA_W-1:0] wb_data_c;

   assign operands_ok = bus.src_ready[src1_q] & bus.src_ready[src2_q];
   assign accept      = bus.issue_valid & issue_rdy;
   assign exec_done   = (state_q == StExec) && (cnt_q == '0);

   int_alu16 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a      (opa_q),
      .b      (opb_q),
      .op     (op_q),
      .result (alu_result)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StRead;
         StRead: if (operands_ok) state_d = StExec;
         StExec: if (cnt_q == '0) state_d = StWb;
         StWb: begin
            if (bus.wb_ready) begin
`ifdef INT_FU_B2B_EN
               state_d = accept ? StRead : StIdle;
`else
               state_d = StIdle;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      issue_rdy = 1'b0;
      rd_en     = 1'b0;
      rd_addr1  = '0;
      rd_addr2  = '0;
      wb_vld    = 1'b0;
      wb_dst_c  = '0;
      wb_data_c = '0;
      busy_c    = 1'b1;
      unique case (state_q)
         StIdle: begin
            // Held low while reset is asserted so every output reads 0.
            issue_rdy = rst_n;
            busy_c    = 1'b0;
         end
         StRead: begin
            rd_en    = operands_ok;
            rd_addr1 = src1_q;
            rd_addr2 = src2_q;
         end
         StExec: busy_c = 1'b1;
         StWb: begin
            wb_vld    = 1'b1;
            wb_dst_c  = dst_q;
            wb_data_c = result_q;
`ifdef INT_FU_B2B_EN
            issue_rdy = bus.wb_ready;
`endif
         end
         default: busy_c = 1'b0;
      endcase
   end

   assign bus.issue_ready = issue_rdy;
   assign bus.rf_rd_en    = rd_en;
   assign bus.rf_rd_addr1 = rd_addr1;
   assign bus.rf_rd_addr2 = rd_addr2;
   assign bus.wb_valid    = wb_vld;
   assign bus.wb_dst      = wb_dst_c;
   assign bus.wb_data     = wb_data_c;
   assign bus.busy        = busy_c;

   // Datapath: instruction fields, operands, execute counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= OpAdd;
         dst_q    <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q   <= fu_op_e'(bus.issue_op);
            dst_q  <= bus.issue_dst;
            src1_q <= bus.issue_src1;
            src2_q <= bus.issue_src2;
         end
         if (rd_en) begin
            opa_q <= bus.rf_rd_data1;
            opb_q <= bus.rf_rd_data2;
            cnt_q <= CntLoad;
         end else if ((state_q == StExec) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         // Result registered once, on the last execute cycle.
         if (exec_done) begin
            result_q <= alu_result;
         end
      end
   end

endmodule

// File: tb/tb_int_fu_ctrl.sv
// tb_int_fu_ctrl -- directed self-checking bench for int_fu_ctrl.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the falling
// edge. Define INT_FU_B2B_EN for both bench and RTL to cover the back-to-back
// build.
module tb_int_fu_ctrl;
   import int_fu_pkg::*;

   localparam int unsigned DATA_W      = 16;
   localparam int unsigned EXEC_CYCLES = 2;
`ifdef INT_FU_B2B_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [DATA_W-1:0] rf [8];

   int_fu_ctrl_if #(.DATA_W(DATA_W)) bus ();

   int_fu_ctrl #(
      .DATA_W      (DATA_W),
      .EXEC_CYCLES (EXEC_CYCLES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.rf_rd_data1 = rf[bus.rf_rd_addr1];
   assign bus.rf_rd_data2 = rf[bus.rf_rd_addr2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.issue_valid = 1'b0;
      bus.issue_op    = 2'b00;
      bus.issue_dst   = 3'd0;
      bus.issue_src1  = 3'd0;
      bus.issue_src2  = 3'd0;
      bus.src_ready   = 8'hFF;
      bus.wb_ready    = 1'b1;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({bus.issue_ready, bus.busy, bus.rf_rd_en, bus.wb_valid} !== 4'b0000)
         begin failures++; $display("FAIL reset_flags got %b want 0000",
            {bus.issue_ready, bus.busy, bus.rf_rd_en, bus.wb_valid}); end
      checks++;
      if ({bus.wb_dst, bus.wb_data, bus.rf_rd_addr1, bus.rf_rd_addr2} !== '0)
         begin failures++; $display("FAIL reset_buses got dst=%0h data=%0h a1=%0h a2=%0h want 0",
            bus.wb_dst, bus.wb_data, bus.rf_rd_addr1, bus.rf_rd_addr2); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.issue_ready, bus.busy} !== 2'b10)
         begin failures++; $display("FAIL reset_release got ready/busy=%b want 10",
            {bus.issue_ready, bus.busy}); end
      step();
   endtask

   // One instruction with no stalls and wb_ready=1; checks timing and result.
   task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] dst,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [DATA_W-1:0] exp);
      int lat;
      bus.issue_op    = op;
      bus.issue_dst   = dst;
      bus.issue_src1  = s1;
      bus.issue_src2  = s2;
      bus.issue_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.issue_ready !== 1'b1)
         begin failures++; $display("FAIL %s_issue_ready got %b want 1", name, bus.issue_ready); end
      step();
      bus.issue_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.rf_rd_en, bus.rf_rd_addr1, bus.rf_rd_addr2} !== {1'b1, s1, s2})
         begin failures++; $display("FAIL %s_read got en=%b a1=%0d a2=%0d want 1 %0d %0d", name,
            bus.rf_rd_en, bus.rf_rd_addr1, bus.rf_rd_addr2, s1, s2); end
      lat = 1;
      while (bus.wb_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 2 + EXEC_CYCLES)
         begin failures++; $display("FAIL %s_latency got %0d want %0d", name, lat,
            2 + EXEC_CYCLES); end
      checks++;
      if ({bus.wb_dst, bus.wb_data} !== {dst, exp})
         begin failures++; $display("FAIL %s_result got dst=%0d data=%h want dst=%0d data=%h",
            name, bus.wb_dst, bus.wb_data, dst, exp); end
      step();
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready} !== {21'd0, 1'b1})
         begin failures++; $display("FAIL %s_idle got busy=%b v=%b dst=%0d data=%h ir=%b want 0 0 0 0 1",
            name, bus.busy, bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready); end
      step();
   endtask

   task automatic test_alu_ops();
      run_op("xor",      2'b10, 3'd3, 3'd1, 3'd2, 16'd14);
      run_op("sub_wrap", 2'b01, 3'd4, 3'd2, 3'd1, 16'hFFFE);
      run_op("sub_pos",  2'b01, 3'd4, 3'd1, 3'd2, 16'd2);
      run_op("add_wrap", 2'b00, 3'd0, 3'd7, 3'd7, 16'hFFFE);
      run_op("and_dst",  2'b11, 3'd3, 3'd3, 3'd4, 16'd8);
   endtask

   task automatic test_stall();
      int lat;
      bus.src_ready   = 8'hFB;
      bus.issue_op    = 2'b00;
      bus.issue_dst   = 3'd4;
      bus.issue_src1  = 3'd1;
      bus.issue_src2  = 3'd2;
      bus.issue_valid = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.rf_rd_en, bus.busy, bus.rf_rd_addr2} !== {1'b0, 1'b1, 3'd2})
            begin failures++; $display("FAIL stall_cycle%0d got en=%b busy=%b a2=%0d want 0 1 2", i,
               bus.rf_rd_en, bus.busy, bus.rf_rd_addr2); end
         step();
      end
      bus.src_ready = 8'hFF;
      @(negedge clk);
      checks++;
      if (bus.rf_rd_en !== 1'b1)
         begin failures++; $display("FAIL stall_release got en=%b want 1", bus.rf_rd_en); end
      lat = 0;
      while (bus.wb_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 1 + EXEC_CYCLES || bus.wb_data !== 16'd14 || bus.wb_dst !== 3'd4)
         begin failures++; $display("FAIL stall_result got lat=%0d data=%h dst=%0d want %0d 000e 4",
            lat, bus.wb_data, bus.wb_dst, 1 + EXEC_CYCLES); end
      step();
      step();
   endtask

   task automatic test_backpressure();
      int lat;
      bus.wb_ready    = 1'b0;
      bus.issue_op    = 2'b01;
      bus.issue_dst   = 3'd5;
      bus.issue_src1  = 3'd2;
      bus.issue_src2  = 3'd1;
      bus.issue_valid = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (bus.wb_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready} !==
             {1'b1, 3'd5, 16'hFFFE, 1'b0})
            begin failures++; $display("FAIL bp_hold%0d got v=%b dst=%0d data=%h ir=%b want 1 5 fffe 0",
               i, bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready); end
         @(negedge clk);
      end
      bus.wb_ready = 1'b1;
      #1;
      checks++;
      if ({bus.wb_valid, bus.issue_ready} !== {1'b1, B2B})
         begin failures++; $display("FAIL bp_grant got v=%b ir=%b want 1 %b",
            bus.wb_valid, bus.issue_ready, B2B); end
      step();
      @(negedge clk);
      checks++;
      if ({bus.wb_valid, bus.busy, bus.wb_data} !== '0)
         begin failures++; $display("FAIL bp_done got v=%b busy=%b data=%h want 0 0 0",
            bus.wb_valid, bus.busy, bus.wb_data); end
      step();
   endtask

   task automatic test_reset_mid_exec();
      bus.issue_op    = 2'b00;
      bus.issue_dst   = 3'd6;
      bus.issue_src1  = 3'd5;
      bus.issue_src2  = 3'd6;
      bus.issue_valid = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.issue_ready, bus.busy, bus.rf_rd_en, bus.wb_valid, bus.wb_dst, bus.wb_data,
           bus.rf_rd_addr1, bus.rf_rd_addr2} !== '0)
         begin failures++; $display("FAIL rst_exec_outputs got ir=%b busy=%b en=%b v=%b data=%h want 0",
            bus.issue_ready, bus.busy, bus.rf_rd_en, bus.wb_valid, bus.wb_data); end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.wb_valid, bus.busy, bus.issue_ready} !== 3'b001)
            begin failures++; $display("FAIL rst_exec_after%0d got v/busy/ir=%b want 001", i,
               {bus.wb_valid, bus.busy, bus.issue_ready}); end
      end
      step();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bus.wb_ready    = 1'b1;
      bus.issue_op    = 2'b00;
      bus.issue_dst   = 3'd1;
      bus.issue_src1  = 3'd5;
      bus.issue_src2  = 3'd6;
      bus.issue_valid = 1'b1;
      step();
      bus.issue_valid = 1'b0;
      step();
      step();
      step();
      // Cycle 4: first result in WB, offer the AND in the same cycle.
      bus.issue_op    = 2'b11;
      bus.issue_dst   = 3'd2;
      bus.issue_src1  = 3'd3;
      bus.issue_src2  = 3'd4;
      bus.issue_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready} !== {1'b1, 3'd1, 16'd12, B2B})
         begin failures++; $display("FAIL b2b_first got v=%b dst=%0d data=%h ir=%b want 1 1 000c %b",
            bus.wb_valid, bus.wb_dst, bus.wb_data, bus.issue_ready, B2B); end
      step();
      bus.issue_valid = !B2B;
      @(negedge clk);
      checks++;
      if ({bus.rf_rd_en, bus.busy, bus.issue_ready, bus.wb_valid} !== {B2B, B2B, !B2B, 1'b0})
         begin failures++; $display("FAIL b2b_cycle5 got en=%b busy=%b ir=%b v=%b want %b %b %b 0",
            bus.rf_rd_en, bus.busy, bus.issue_ready, bus.wb_valid, B2B, B2B, !B2B); end
      step();
      bus.issue_valid = 1'b0;
      cyc = 6;
      @(negedge clk);
      while (bus.wb_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != (B2B ? 8 : 9))
         begin failures++; $display("FAIL b2b_second_cycle got %0d want %0d", cyc,
            B2B ? 8 : 9); end
      checks++;
      if ({bus.wb_dst, bus.wb_data} !== {3'd2, 16'd8})
         begin failures++; $display("FAIL b2b_second_result got dst=%0d data=%h want 2 0008",
            bus.wb_dst, bus.wb_data); end
      step();
      step();
   endtask

   initial begin
      rf[0] = 16'h0000;
      rf[1] = 16'd8;
      rf[2] = 16'd6;
      rf[3] = 16'd12;
      rf[4] = 16'd10;
      rf[5] = 16'd5;
      rf[6] = 16'd7;
      rf[7] = 16'hFFFF;
      test_reset();
      test_alu_ops();
      test_stall();
      test_backpressure();
      test_reset_mid_exec();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/int_fu_ctrl.md
INT_FU_CTRL -- requirements
Module: int_fu_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter EXEC_CYCLES, default 2, execute-stage latency, legal range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port issue_valid  in  1  issue request from the scoreboard.
REQ-006 SHALL have port issue_ready  out  1  unit free to accept an instruction.
REQ-007 SHALL have port issue_op  in  2  operation code: 00 ADD, 01 SUB, 10 XOR, 11 AND.
REQ-008 SHALL have ports issue_dst, issue_src1, issue_src2  in  3 each  register indices (Fi, Fj, Fk).
REQ-009 SHALL have port src_ready  in  8  per-register ready bitmap (1 = no pending writer).
REQ-010 SHALL have port rf_rd_en  out  1  register-file read strobe.
REQ-011 SHALL have ports rf_rd_addr1, rf_rd_addr2  out  3 each  read addresses.
REQ-012 SHALL have ports rf_rd_data1, rf_rd_data2  in  DATA_W each  read data, valid in the same cycle as rf_rd_en.
REQ-013 SHALL have port wb_valid  out  1  result available.
REQ-014 SHALL have port wb_ready  in  1  scoreboard grants write-back (no WAR hazard).
REQ-015 SHALL have ports wb_dst  out  3, wb_data  out  DATA_W  destination and result.
REQ-016 SHALL have port busy  out  1  functional-unit status Busy flag.

Function
REQ-017 SHALL implement FSM states IDLE, READ, EXEC, WB.
REQ-018 IDLE: issue_ready=1; issue_valid=1 latches op/dst/src1/src2 and moves to READ; no other state asserts issue_ready except per REQ-029.
REQ-019 READ: rf_rd_en=1 and operands captured only in a cycle where src_ready[src1] and src_ready[src2] are both 1, then EXEC; otherwise stall in READ with rf_rd_en=0.
REQ-020 rf_rd_addr1/2 SHALL equal latched src1/src2 whenever state is READ, else 0.
REQ-021 EXEC: down-counter loaded with EXEC_CYCLES-1, moves to WB when it reaches 0; result computed once by the ALU and registered.
REQ-022 Arithmetic: ADD a+b, SUB a-b, both modulo 2^DATA_W, carry/borrow discarded; XOR a^b; AND a&b.
REQ-023 WB: wb_valid=1 with stable wb_dst/wb_data until wb_ready=1; transfer on valid&ready, then IDLE.
REQ-024 Latency with no stalls: accept in cycle 0, read in cycle 1, wb_valid first high in cycle 2+EXEC_CYCLES.
REQ-025 busy SHALL be 1 in READ, EXEC, WB; 0 in IDLE.
REQ-026 src1==src2 and src==dst SHALL be legal and need no special handling.
REQ-027 wb_data/wb_dst SHALL be 0 whenever wb_valid=0.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, clear latched fields, counter, result; all outputs 0 except issue_ready=1 once rst_n high; in-flight instruction discarded without write-back.

Configuration
REQ-029 With INT_FU_B2B_EN defined, issue_ready SHALL also be 1 in WB while wb_ready=1, and a simultaneous issue_valid SHALL latch the new instruction and go WB->READ directly; without it, WB always returns to IDLE (one bubble cycle).

Structure
REQ-030 Package int_fu_pkg SHALL hold the op-code enum, FSM state enum and the DATA_W default.
REQ-031 Combinational sub-module int_alu16 (a, b, op -> result) SHALL perform REQ-022; the controller instantiates it once.

Verification
REQ-032 XOR: r1=8, r2=6, issue op=10 dst=3, all ready, wb_ready=1 -> wb_valid in cycle 4, wb_dst=3, wb_data=14.
REQ-033 SUB wrap: a=6, b=8, op=01 -> wb_data=16'hFFFE; a=8, b=6 -> 2.
REQ-034 Operand stall: src_ready[2]=0 for 5 cycles after issue -> rf_rd_en stays 0, busy=1, read occurs the cycle bit 2 rises.
REQ-035 Back-pressure: wb_ready=0 for 3 cycles -> wb_valid, wb_dst, wb_data held stable; issue_ready=0 throughout.
REQ-036 Reset mid-EXEC: rst_n low -> next sampled outputs all 0, no wb_valid after release, issue_ready=1.
REQ-037 Back-to-back ADD 5+7 then AND 12&10: with INT_FU_B2B_EN second accepted in WB cycle (results 12, 8), without it one IDLE cycle between.
